// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Multicycle control FSM for the 16-bit RISC datapath. Each instruction is
// sequenced through IF/ID/EX/MEM/WB, with short paths for branches, NOPs and
// stores. HLT parks the controller in HALT with done=1 until reset.
//
// State | meaning
// ------+-------------------------------------------------------------
// IF    | fetch: load instruction buffer
// ID    | decode; branches, NOP/OutR and HLT finish here
// EX    | ALU operation / address generation
// MEM   | memory access or write-back source select; stores finish here
// WB    | register-file write, PC update
// HALT  | halted, done=1, waits for reset
//
// Ports
//   clk          in   system clock, rising edge
//   Rst          in   asynchronous active-low reset
//   opcode       in   5-bit instruction opcode (valid from ID onward)
//   ALUopcode    in   2-bit ALU sub-op for opcode 00000
//   PSW_NZC      in   registered flags {N,Z,C}
//   Buff_MEMIns  out  load instruction buffer
//   ALUorNot, LIorMOV, MEMresource, WE_MEM            out  memory stage
//   WBresource, RBresource, oprandB, LI, PCplus1orWB,
//   WE_RF                                             out  register file
//   Flag, ALUop, Buff_PSW                             out  ALU / flags
//   Branch       out  take PC-relative branch
//   Jump         out  reserved, always 2'b00
//   Buff_PC      out  update PC
//   done         out  high while halted
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       Rst,
    input  logic [4:0] opcode,
    input  logic [1:0] ALUopcode,
    input  logic [2:0] PSW_NZC,
    output logic       Buff_MEMIns,
    output logic       ALUorNot,
    output logic       LIorMOV,
    output logic       MEMresource,
    output logic       WE_MEM,
    output logic       WBresource,
    output logic       RBresource,
    output logic       oprandB,
    output logic       LI,
    output logic       PCplus1orWB,
    output logic       WE_RF,
    output logic       Flag,
    output logic       ALUop,
    output logic       Buff_PSW,
    output logic       Branch,
    output logic [1:0] Jump,
    output logic       Buff_PC,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_LHI   = 5'b00001;
    localparam logic [4:0] OP_LLI   = 5'b00010;
    localparam logic [4:0] OP_LDRRI = 5'b00011;
    localparam logic [4:0] OP_LDRRR = 5'b00100;
    localparam logic [4:0] OP_STRRI = 5'b00101;
    localparam logic [4:0] OP_STRRR = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b00111;
    localparam logic [4:0] OP_SUBI  = 5'b01000;
    localparam logic [4:0] OP_MOV   = 5'b01001;
    localparam logic [4:0] OP_BCC   = 5'b11000;
    localparam logic [4:0] OP_BCS   = 5'b11001;
    localparam logic [4:0] OP_BNE   = 5'b11010;
    localparam logic [4:0] OP_BEQ   = 5'b11011;
    localparam logic [4:0] OP_BAL   = 5'b11100;
    localparam logic [4:0] OP_HLT   = 5'b11111;

    state_t state_q, state_d;

    logic is_alu, is_lhi, is_lli, is_ldr, is_str, is_addi, is_subi, is_mov;
    logic is_branch, is_hlt, is_exec, is_imm;
    logic br_cond;
    logic flag_c, flag_z;
    logic unused_flag_n;

    assign flag_c        = PSW_NZC[0];
    assign flag_z        = PSW_NZC[1];
    assign unused_flag_n = PSW_NZC[2];

    assign is_alu    = (opcode == OP_ALU);
    assign is_lhi    = (opcode == OP_LHI);
    assign is_lli    = (opcode == OP_LLI);
    assign is_ldr    = (opcode == OP_LDRRI) || (opcode == OP_LDRRR);
    assign is_str    = (opcode == OP_STRRI) || (opcode == OP_STRRR);
    assign is_addi   = (opcode == OP_ADDI);
    assign is_subi   = (opcode == OP_SUBI);
    assign is_mov    = (opcode == OP_MOV);
    assign is_hlt    = (opcode == OP_HLT);
    assign is_branch = (opcode == OP_BCC) || (opcode == OP_BCS) ||
                       (opcode == OP_BNE) || (opcode == OP_BEQ) ||
                       (opcode == OP_BAL);

    // Instructions that continue past ID; everything unrecognised is a NOP.
    assign is_exec = is_alu || is_lhi || is_lli || is_ldr || is_str ||
                     is_addi || is_subi || is_mov;
    // Immediate forms select the sign-extended immediate as operand B.
    assign is_imm  = (opcode == OP_LDRRI) || (opcode == OP_STRRI) ||
                     is_addi || is_subi;

    // BAL is encoded as a branch but never asserts Branch.
    always_comb begin
        br_cond = 1'b0;
        unique case (opcode)
            OP_BCC:  br_cond = ~flag_c;
            OP_BCS:  br_cond = flag_c;
            OP_BNE:  br_cond = ~flag_z;
            OP_BEQ:  br_cond = flag_z;
            default: br_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        Buff_MEMIns = 1'b0;
        ALUorNot    = 1'b0;
        LIorMOV     = 1'b0;
        MEMresource = 1'b0;
        WE_MEM      = 1'b0;
        WBresource  = 1'b0;
        RBresource  = 1'b0;
        oprandB     = 1'b0;
        LI          = 1'b0;
        PCplus1orWB = 1'b0;
        WE_RF       = 1'b0;
        Flag        = 1'b0;
        ALUop       = 1'b0;
        Buff_PSW    = 1'b0;
        Branch      = 1'b0;
        Jump        = 2'b00;
        Buff_PC     = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            S_IF: begin
                Buff_MEMIns = 1'b1;
                state_d     = S_ID;
            end

            S_ID: begin
                if (is_branch) begin
                    Branch  = br_cond;
                    Buff_PC = 1'b1;
                    state_d = S_IF;
                end else if (is_hlt) begin
                    Buff_PC = 1'b1;
                    state_d = S_HALT;
                end else if (is_exec) begin
                    RBresource = is_lhi;
                    LI         = is_lhi;
                    oprandB    = is_imm;
                    state_d    = S_EX;
                end else begin
                    Buff_PC = 1'b1;
                    state_d = S_IF;
                end
            end

            S_EX: begin
                if (is_alu) begin
                    // ALUopcode[0] selects carry-in (ADC/SBB), [1] selects subtract.
                    Flag     = ALUopcode[0];
                    ALUop    = ALUopcode[1];
                    Buff_PSW = 1'b1;
                end else if (is_addi) begin
                    Buff_PSW = 1'b1;
                end else if (is_subi) begin
                    ALUop    = 1'b1;
                    Buff_PSW = 1'b1;
                end else if (is_str) begin
                    // Store data comes through the second read port.
                    RBresource = 1'b1;
                end
                state_d = S_MEM;
            end

            S_MEM: begin
                state_d = S_WB;
                if (is_lhi || is_lli) begin
                    ALUorNot = 1'b1;
                end else if (is_mov) begin
                    ALUorNot = 1'b1;
                    LIorMOV  = 1'b1;
                end else if (is_ldr) begin
                    MEMresource = 1'b1;
                end else if (is_str) begin
                    MEMresource = 1'b1;
                    WE_MEM      = 1'b1;
                    Buff_PC     = 1'b1;
                    state_d     = S_IF;
                end
            end

            S_WB: begin
                WE_RF       = 1'b1;
                Buff_PC     = 1'b1;
                PCplus1orWB = 1'b1;
                WBresource  = is_ldr;
                state_d     = S_IF;
            end

            S_HALT: begin
                done = 1'b1;
            end

            default: begin
                state_d = S_IF;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       Rst;
    logic [4:0] opcode;
    logic [1:0] ALUopcode;
    logic [2:0] PSW_NZC;
    logic       Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM;
    logic       WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF;
    logic       Flag, ALUop, Buff_PSW, Branch, Buff_PC, done;
    logic [1:0] Jump;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk         (clk),
        .Rst         (Rst),
        .opcode      (opcode),
        .ALUopcode   (ALUopcode),
        .PSW_NZC     (PSW_NZC),
        .Buff_MEMIns (Buff_MEMIns),
        .ALUorNot    (ALUorNot),
        .LIorMOV     (LIorMOV),
        .MEMresource (MEMresource),
        .WE_MEM      (WE_MEM),
        .WBresource  (WBresource),
        .RBresource  (RBresource),
        .oprandB     (oprandB),
        .LI          (LI),
        .PCplus1orWB (PCplus1orWB),
        .WE_RF       (WE_RF),
        .Flag        (Flag),
        .ALUop       (ALUop),
        .Buff_PSW    (Buff_PSW),
        .Branch      (Branch),
        .Jump        (Jump),
        .Buff_PC     (Buff_PC),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {Buff_MEMIns, ALUorNot, LIorMOV, MEMresource, WE_MEM,
                  WBresource, RBresource, oprandB, LI, PCplus1orWB, WE_RF,
                  Flag, ALUop, Buff_PSW, Branch, Jump, Buff_PC, done};

    localparam logic [18:0] Z0       = 19'h0;
    localparam logic [18:0] M_MEMINS = 19'h1 << 18;
    localparam logic [18:0] M_ALUNOT = 19'h1 << 17;
    localparam logic [18:0] M_LIMOV  = 19'h1 << 16;
    localparam logic [18:0] M_MEMRES = 19'h1 << 15;
    localparam logic [18:0] M_WEMEM  = 19'h1 << 14;
    localparam logic [18:0] M_WBRES  = 19'h1 << 13;
    localparam logic [18:0] M_RBRES  = 19'h1 << 12;
    localparam logic [18:0] M_OPB    = 19'h1 << 11;
    localparam logic [18:0] M_LI     = 19'h1 << 10;
    localparam logic [18:0] M_PCWB   = 19'h1 << 9;
    localparam logic [18:0] M_WERF   = 19'h1 << 8;
    localparam logic [18:0] M_FLAG   = 19'h1 << 7;
    localparam logic [18:0] M_ALUOP  = 19'h1 << 6;
    localparam logic [18:0] M_PSW    = 19'h1 << 5;
    localparam logic [18:0] M_BR     = 19'h1 << 4;
    localparam logic [18:0] M_BPC    = 19'h1 << 1;
    localparam logic [18:0] M_DONE   = 19'h1;

    localparam logic [18:0] V_IF = M_MEMINS;
    localparam logic [18:0] V_WB = M_WERF | M_BPC | M_PCWB;

    task automatic test_reset();
        Rst = 1'b0;
        opcode = 5'b01010;
        ALUopcode = 2'b00;
        PSW_NZC = 3'b000;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL reset_hold obs=%h exp=%h", obs, V_IF);
        end
        Rst = 1'b1;
        #1;
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL reset_release obs=%h exp=%h", obs, V_IF);
        end
        @(negedge clk);
        checks++;
        if (obs !== M_BPC) begin
            errors++;
            $display("FAIL reset_first_id obs=%h exp=%h", obs, M_BPC);
        end
        @(negedge clk);
    endtask

    task automatic test_lli_lhi();
        logic [18:0] seq [2][5];
        logic [4:0]  ops [2];
        ops[0] = 5'b00010;
        ops[1] = 5'b00001;
        seq[0] = '{V_IF, Z0, Z0, M_ALUNOT, V_WB};
        seq[1] = '{V_IF, M_RBRES | M_LI, Z0, M_ALUNOT, V_WB};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== seq[k][i]) begin
                    errors++;
                    $display("FAIL li op=%b cyc=%0d obs=%h exp=%h", ops[k], i, obs, seq[k][i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_alu();
        logic [18:0] seq [4][5];
        logic [4:0]  ops [4];
        logic [1:0]  sub [4];
        ops[0] = 5'b00000; sub[0] = 2'b10;
        ops[1] = 5'b00000; sub[1] = 2'b01;
        ops[2] = 5'b00111; sub[2] = 2'b11;
        ops[3] = 5'b01000; sub[3] = 2'b00;
        seq[0] = '{V_IF, Z0, M_ALUOP | M_PSW, Z0, V_WB};
        seq[1] = '{V_IF, Z0, M_FLAG | M_PSW, Z0, V_WB};
        seq[2] = '{V_IF, M_OPB, M_PSW, Z0, V_WB};
        seq[3] = '{V_IF, M_OPB, M_ALUOP | M_PSW, Z0, V_WB};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            ALUopcode = sub[k];
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== seq[k][i]) begin
                    errors++;
                    $display("FAIL alu op=%b sub=%b cyc=%0d obs=%h exp=%h", ops[k], sub[k], i, obs, seq[k][i]);
                end
                @(negedge clk);
            end
        end
        ALUopcode = 2'b00;
    endtask

    task automatic test_mov_load();
        logic [18:0] seq [2][5];
        logic [4:0]  ops [2];
        ops[0] = 5'b01001;
        ops[1] = 5'b00011;
        seq[0] = '{V_IF, Z0, Z0, M_ALUNOT | M_LIMOV, V_WB};
        seq[1] = '{V_IF, M_OPB, Z0, M_MEMRES, V_WB | M_WBRES};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs !== seq[k][i]) begin
                    errors++;
                    $display("FAIL movld op=%b cyc=%0d obs=%h exp=%h", ops[k], i, obs, seq[k][i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_store();
        logic [18:0] seq [2][4];
        logic [4:0]  ops [2];
        ops[0] = 5'b00101;
        ops[1] = 5'b00110;
        seq[0] = '{V_IF, M_OPB, M_RBRES, M_MEMRES | M_WEMEM | M_BPC};
        seq[1] = '{V_IF, Z0, M_RBRES, M_MEMRES | M_WEMEM | M_BPC};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs !== seq[k][i]) begin
                    errors++;
                    $display("FAIL store op=%b cyc=%0d obs=%h exp=%h", ops[k], i, obs, seq[k][i]);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL store_next_if obs=%h exp=%h", obs, V_IF);
        end
    endtask

    task automatic test_branches();
        logic [4:0]  ops [8];
        logic [2:0]  psw [8];
        logic [18:0] id_exp [8];
        ops[0] = 5'b11001; psw[0] = 3'b001; id_exp[0] = M_BR | M_BPC;
        ops[1] = 5'b11001; psw[1] = 3'b110; id_exp[1] = M_BPC;
        ops[2] = 5'b11000; psw[2] = 3'b110; id_exp[2] = M_BR | M_BPC;
        ops[3] = 5'b11100; psw[3] = 3'b111; id_exp[3] = M_BPC;
        ops[4] = 5'b11010; psw[4] = 3'b001; id_exp[4] = M_BR | M_BPC;
        ops[5] = 5'b11011; psw[5] = 3'b001; id_exp[5] = M_BPC;
        ops[6] = 5'b11011; psw[6] = 3'b010; id_exp[6] = M_BR | M_BPC;
        ops[7] = 5'b10101; psw[7] = 3'b111; id_exp[7] = M_BPC;
        for (int k = 0; k < 8; k++) begin
            opcode = ops[k];
            PSW_NZC = psw[k];
            checks++;
            if (obs !== V_IF) begin
                errors++;
                $display("FAIL br_if op=%b obs=%h exp=%h", ops[k], obs, V_IF);
            end
            @(negedge clk);
            checks++;
            if (obs !== id_exp[k]) begin
                errors++;
                $display("FAIL br_id op=%b psw=%b obs=%h exp=%h", ops[k], psw[k], obs, id_exp[k]);
            end
            @(negedge clk);
        end
        PSW_NZC = 3'b000;
    endtask

    task automatic test_halt();
        opcode = 5'b11111;
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL hlt_if obs=%h exp=%h", obs, V_IF);
        end
        @(negedge clk);
        checks++;
        if (obs !== M_BPC) begin
            errors++;
            $display("FAIL hlt_id obs=%h exp=%h", obs, M_BPC);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) opcode = 5'b00000;
            checks++;
            if (obs !== M_DONE) begin
                errors++;
                $display("FAIL hlt_done cyc=%0d obs=%h exp=%h", i, obs, M_DONE);
            end
        end
    endtask

    task automatic test_reset_mid();
        Rst = 1'b0;
        #1;
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL rst_from_halt obs=%h exp=%h", obs, V_IF);
        end
        @(negedge clk);
        Rst = 1'b1;
        opcode = 5'b00100;
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL ldr_if obs=%h exp=%h", obs, V_IF);
        end
        @(negedge clk);
        checks++;
        if (obs !== Z0) begin
            errors++;
            $display("FAIL ldr_id obs=%h exp=%h", obs, Z0);
        end
        @(negedge clk);
        checks++;
        if (obs !== Z0) begin
            errors++;
            $display("FAIL ldr_ex obs=%h exp=%h", obs, Z0);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL rst_mid_immediate obs=%h exp=%h", obs, V_IF);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_IF) begin
                errors++;
                $display("FAIL rst_mid_hold cyc=%0d obs=%h exp=%h", i, obs, V_IF);
            end
        end
        Rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== Z0) begin
            errors++;
            $display("FAIL ldr2_id obs=%h exp=%h", obs, Z0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== M_MEMRES) begin
            errors++;
            $display("FAIL ldr2_mem obs=%h exp=%h", obs, M_MEMRES);
        end
        @(negedge clk);
        checks++;
        if (obs !== (V_WB | M_WBRES)) begin
            errors++;
            $display("FAIL ldr2_wb obs=%h exp=%h", obs, V_WB | M_WBRES);
        end
        @(negedge clk);
        checks++;
        if (obs !== V_IF) begin
            errors++;
            $display("FAIL ldr2_next_if obs=%h exp=%h", obs, V_IF);
        end
    endtask

    initial begin
        test_reset();
        test_lli_lhi();
        test_alu();
        test_mov_load();
        test_store();
        test_branches();
        test_halt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
